// File: rtl/vga_pkg.sv
// vga_pkg: VGA 640x480@60 timing constants, pattern modes and TinyVGA PMOD pin map
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END = VS_START + V_SYNC - 1;
  localparam logic [9:0] BAR_WIDTH = 10'd80;
  localparam logic [7:0] UO_IDLE = 8'h88;
  localparam int UO_R1 = 0;
  localparam int UO_G1 = 1;
  localparam int UO_B1 = 2;
  localparam int UO_VSYNC = 3;
  localparam int UO_R0 = 4;
  localparam int UO_G0 = 5;
  localparam int UO_B0 = 6;
  localparam int UO_HSYNC = 7;
  typedef enum logic [1:0] {MODE_XOR, MODE_BARS, MODE_CHECKER, MODE_SOLID} mode_e;
endpackage

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters with negative-polarity syncs and visible-area flag
module vga_sync_gen #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BACK = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT = vga_pkg::V_FRONT,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BACK = vga_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [7:0] frame
);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [7:0] frame_q, frame_d;
  logic h_wrap, v_wrap;
  always_comb begin
    h_wrap = hpos_q == H_LAST;
    v_wrap = vpos_q == V_LAST;
    hpos_d = h_wrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d = h_wrap ? (v_wrap ? 10'd0 : vpos_q + 10'd1) : vpos_q;
    frame_d = frame_q + 8'(h_wrap && v_wrap);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q <= '0;
      vpos_q <= '0;
      frame_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      frame_q <= frame_d;
    end
  end
  assign hsync = !(hpos_q >= HS_FIRST && hpos_q <= HS_LAST);
  assign vsync = !(vpos_q >= VS_FIRST && vpos_q <= VS_LAST);
  assign display_on = hpos_q < H_VIS && vpos_q < V_VIS;
  assign hpos = hpos_q;
  assign vpos = vpos_q;
  assign frame = frame_q;
endmodule

// File: rtl/vga_playground.sv
// vga_playground: selectable animated VGA test pattern on TinyVGA PMOD pin order
module vga_playground #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BACK = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT = vga_pkg::V_FRONT,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BACK = vga_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import vga_pkg::*;
  logic hsync, vsync, display_on, unused;
  logic [9:0] hpos, vpos;
  logic [7:0] frame, xor_v, uo_d, uo_q;
  logic [2:0] bar;
  logic [5:0] col, pix;
  mode_e mode;
  vga_sync_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .hsync(hsync),
    .vsync(vsync),
    .display_on(display_on),
    .hpos(hpos),
    .vpos(vpos),
    .frame(frame)
  );
  always_comb begin
    mode = mode_e'(ui_in[1:0]);
    xor_v = (hpos[7:0] ^ vpos[7:0]) + frame;
    bar = 3'(hpos / BAR_WIDTH);
    col = mode == MODE_XOR ? xor_v[7:2] :
          mode == MODE_BARS ? {{2{bar[2]}}, {2{bar[1]}}, {2{bar[0]}}} :
          mode == MODE_CHECKER ? {6{hpos[5] ^ vpos[5] ^ frame[6]}} : ui_in[7:2];
    pix = display_on ? col : 6'd0;
    uo_d = '0;
    uo_d[UO_R1] = pix[5];
    uo_d[UO_R0] = pix[4];
    uo_d[UO_G1] = pix[3];
    uo_d[UO_G0] = pix[2];
    uo_d[UO_B1] = pix[1];
    uo_d[UO_B0] = pix[0];
    uo_d[UO_VSYNC] = vsync;
    uo_d[UO_HSYNC] = hsync;
  end
  always_ff @(posedge clk) uo_q <= rst ? UO_IDLE : uo_d;
  assign uo_out = uo_q;
  assign uio_out = '0;
  assign uio_oe = '0;
  assign unused = &{1'b0, ena, uio_in, vpos[9:8]};
endmodule

// File: tb/tb_vga_playground.sv
// tb_vga_playground: directed timing and pattern checks on a vertically shortened raster
module tb_vga_playground;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t0, t1;
  always #5 clk = ~clk;
  vga_playground #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .ui_in(ui_in),
    .uio_in(uio_in),
    .uo_out(uo_out),
    .uio_out(uio_out),
    .uio_oe(uio_oe)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask
  task automatic goto(input int t);
    while (cyc < t) step();
  endtask
  task automatic px(input string tag, input int t, input logic [7:0] exp);
    goto(t);
    chk(tag, uo_out, exp);
  endtask
  task automatic seek(input int b, input logic lvl, output int at);
    at = -1;
    for (int i = 0; i < 8000; i++) begin
      step();
      if (uo_out[b] === lvl) begin
        at = cyc;
        break;
      end
    end
  endtask
  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_uo", uo_out, 8'h88);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h00);
    rst = 1'b0;
    step();
    chk("xor_f0_0_0", uo_out, 8'h88);
    ui_in = 8'hDB;
    seek(7, 1'b0, t0);
    chk("hs_fall0", t0, 657);
    seek(7, 1'b1, t1);
    chk("hs_width0", t1 - t0, 96);
    for (int l = 1; l < 3; l++) begin
      seek(7, 1'b0, t1);
      chk("hs_period", t1 - t0, 800);
      t0 = t1;
      seek(7, 1'b1, t1);
      chk("hs_width", t1 - t0, 96);
    end
    px("solid_100_3", 2501, 8'hBD);
    px("solid_639_3", 3040, 8'hBD);
    px("solid_640_3", 3041, 8'h88);
    px("solid_700_3_hs", 3101, 8'h08);
    px("solid_100_4_vblank", 3301, 8'h88);
    seek(3, 1'b0, t0);
    chk("vs_fall0", t0, 4001);
    seek(3, 1'b1, t1);
    chk("vs_width", t1 - t0, 1600);
    ui_in = 8'h00;
    px("xor_f1_0_0", 6401, 8'h88);
    px("xor_f1_48_0", 6449, 8'hAA);
    px("xor_f1_192_0", 6593, 8'h99);
    ui_in = 8'h01;
    px("bars_0", 7201, 8'h88);
    px("bars_80", 7281, 8'hCC);
    px("bars_240", 7441, 8'hEE);
    px("bars_400", 7601, 8'hDD);
    px("bars_560", 7761, 8'hFF);
    px("bars_639", 7840, 8'hFF);
    px("bars_640", 7841, 8'h88);
    ui_in = 8'h02;
    ena = 1'b0;
    uio_in = 8'hFF;
    px("chk_10_2", 8011, 8'h88);
    px("chk_40_2", 8041, 8'hFF);
    px("chk_70_2", 8071, 8'h88);
    px("chk_100_2", 8101, 8'hFF);
    ui_in = 8'h00;
    px("xor_f4_0_0", 25601, 8'hC8);
    seek(3, 1'b0, t1);
    chk("vs_fall_f4", t1, 29601);
    goto(33901);
    rst = 1'b1;
    step();
    chk("mid_rst_uo", uo_out, 8'h88);
    rst = 1'b0;
    cyc = 0;
    px("restart_0_0", 1, 8'h88);
    px("restart_4_0", 5, 8'hC8);
    seek(7, 1'b0, t0);
    chk("restart_hs_fall", t0, 657);
    px("restart_f1_0_0", 6401, 8'h88);
    px("restart_f1_4_0", 6405, 8'hC8);
    chk("end_uio_out", uio_out, 8'h00);
    chk("end_uio_oe", uio_oe, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
